// File: rtl/br_pkg.sv
// Shared types for the branch resolve unit: condition codes, the flag
// bundle, FSM state encoding and the fall-through PC increment.
package br_pkg;

    typedef enum logic [2:0] {
        NEQ    = 3'b000,
        EQ     = 3'b001,
        GT     = 3'b010,
        LT     = 3'b011,
        GTE    = 3'b100,
        LTE    = 3'b101,
        OVFL   = 3'b110,
        UNCOND = 3'b111
    } cond_e;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational condition evaluator: maps a condition code and a flag
// bundle to a taken decision. Shared by the direct, held and forwarded paths.
module br_cond_eval
    import br_pkg::*;
(
    input  cond_e  cond_i,
    input  flags_t flags_i,
    output logic   taken_o
);

    // Decode the condition code against the supplied flags.
    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            NEQ:    taken_o = !flags_i.z;
            EQ:     taken_o = flags_i.z;
            GT:     taken_o = !flags_i.z && !flags_i.n;
            LT:     taken_o = flags_i.n;
            GTE:    taken_o = flags_i.z || !flags_i.n;
            LTE:    taken_o = flags_i.n || flags_i.z;
            OVFL:   taken_o = flags_i.v;
            UNCOND: taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: latches ALU flags and resolves conditional branches,
// producing taken, target and a one-cycle flush pulse.
// Handshake: a branch request transfers on a clock edge where br_valid and
// br_ready are both high; while br_ready is low the requester holds br_*
// stable. res_valid is a one-cycle pulse; other result outputs hold.
// Build option FLAG_FWD_EN: a flag write coinciding with a branch is
// forwarded straight into the evaluation instead of stalling one cycle.
module branch_resolve_unit
    import br_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CC_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flag_we,
    input  logic            z_in,
    input  logic            v_in,
    input  logic            n_in,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [CC_W-1:0] br_cond,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_offset,
    input  logic            br_pred_taken,
    output logic            res_valid,
    output logic            res_taken,
    output logic [XLEN-1:0] res_target,
    output logic            res_flush,
    output logic [2:0]      flags_q,
    output state_e          state_dbg
);

    flags_t          flags_in;
    flags_t          flags_cur;
    flags_t          eval_flags;
    cond_e           eval_cond;
    logic [XLEN-1:0] eval_pc;
    logic [XLEN-1:0] eval_off;
    logic            eval_pred;
    logic            eval_en;
    logic            eval_taken;
    logic [XLEN-1:0] target_d;
    logic            res_pred_q;

    assign flags_in  = flags_t'({z_in, v_in, n_in});
    assign flags_cur = flags_t'(flags_q);

    // Flag register: load on every flag-setting ALU result, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
        end else if (flag_we) begin
            flags_q <= flags_in;
        end
    end

`ifndef FLAG_FWD_EN
    state_e          state_q, state_d;
    logic            cap;
    cond_e           hold_cond_q;
    logic [XLEN-1:0] hold_pc_q;
    logic [XLEN-1:0] hold_off_q;
    logic            hold_pred_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and evaluation select: a branch racing a flag write is
    // parked for one cycle so it sees the freshly written flags.
    always_comb begin
        state_d    = state_q;
        cap        = 1'b0;
        br_ready   = 1'b0;
        eval_en    = 1'b0;
        eval_cond  = cond_e'(br_cond);
        eval_pc    = br_pc;
        eval_off   = br_offset;
        eval_pred  = br_pred_taken;
        eval_flags = flags_cur;
        case (state_q)
            IDLE: begin
                br_ready = 1'b1;
                if (br_valid) begin
                    if (flag_we) begin
                        cap     = 1'b1;
                        state_d = HOLD;
                    end else begin
                        eval_en = 1'b1;
                    end
                end
            end
            HOLD: begin
                eval_en   = 1'b1;
                eval_cond = hold_cond_q;
                eval_pc   = hold_pc_q;
                eval_off  = hold_off_q;
                eval_pred = hold_pred_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register for the request parked during a flag hazard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cond_q <= NEQ;
            hold_pc_q   <= '0;
            hold_off_q  <= '0;
            hold_pred_q <= 1'b0;
        end else if (cap) begin
            hold_cond_q <= cond_e'(br_cond);
            hold_pc_q   <= br_pc;
            hold_off_q  <= br_offset;
            hold_pred_q <= br_pred_taken;
        end
    end

    assign state_dbg = state_q;
`else
    // Forwarding build: always ready, coincident flag writes feed the evaluator.
    always_comb begin
        br_ready   = 1'b1;
        eval_en    = br_valid;
        eval_cond  = cond_e'(br_cond);
        eval_pc    = br_pc;
        eval_off   = br_offset;
        eval_pred  = br_pred_taken;
        eval_flags = flag_we ? flags_in : flags_cur;
    end

    assign state_dbg = IDLE;
`endif

    br_cond_eval u_cond_eval (
        .cond_i  (eval_cond),
        .flags_i (eval_flags),
        .taken_o (eval_taken)
    );

    // Taken target or fall-through, both modulo 2^XLEN.
    assign target_d = eval_taken ? (eval_pc + eval_off) : (eval_pc + XLEN'(PC_INC));

    // Result registers: valid pulses per evaluation, data holds between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid  <= 1'b0;
            res_taken  <= 1'b0;
            res_target <= '0;
            res_pred_q <= 1'b0;
        end else begin
            res_valid <= eval_en;
            if (eval_en) begin
                res_taken  <= eval_taken;
                res_target <= target_d;
                res_pred_q <= eval_pred;
            end
        end
    end

    assign res_flush = res_valid & (res_taken ^ res_pred_q);

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (honours FLAG_FWD_EN if defined).
module tb_branch_resolve_unit;
    import br_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            flag_we = 1'b0;
    logic            z_in = 1'b0, v_in = 1'b0, n_in = 1'b0;
    logic            br_valid = 1'b0;
    logic            br_ready;
    logic [2:0]      br_cond = 3'd0;
    logic [XLEN-1:0] br_pc = '0;
    logic [XLEN-1:0] br_offset = '0;
    logic            br_pred_taken = 1'b0;
    logic            res_valid, res_taken, res_flush;
    logic [XLEN-1:0] res_target;
    logic [2:0]      flags_q;
    state_e          state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    branch_resolve_unit #(.XLEN(XLEN), .CC_W(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flag_we       (flag_we),
        .z_in          (z_in),
        .v_in          (v_in),
        .n_in          (n_in),
        .br_valid      (br_valid),
        .br_ready      (br_ready),
        .br_cond       (br_cond),
        .br_pc         (br_pc),
        .br_offset     (br_offset),
        .br_pred_taken (br_pred_taken),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .res_target    (res_target),
        .res_flush     (res_flush),
        .flags_q       (flags_q),
        .state_dbg     (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          cond;
        logic [31:0] pc;
        logic [31:0] off;
        bit          pred;
    } req_t;

    bit [2:0]    m_flags  = 3'b000;  // {z,v,n}
    bit          m_pend   = 1'b0;
    req_t        m_preq;
    bit          m_ready  = 1'b1;
    bit          m_valid  = 1'b0;
    bit          m_taken  = 1'b0;
    logic [31:0] m_target = '0;
    bit          m_pred   = 1'b0;

    function automatic bit cond_holds(input int c, input bit [2:0] f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (c)
            0: return !z;
            1: return z;
            2: return !z && !n;
            3: return n;
            4: return z || !n;
            5: return n || z;
            6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic resolve(input req_t r, input bit [2:0] f);
        m_valid  = 1'b1;
        m_taken  = cond_holds(r.cond, f);
        m_target = m_taken ? (r.pc + r.off) : (r.pc + 32'd4);
        m_pred   = r.pred;
    endtask

    initial begin
        req_t cur;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_flags = 3'b000; m_pend = 1'b0; m_ready = 1'b1;
                m_valid = 1'b0; m_taken = 1'b0; m_target = '0; m_pred = 1'b0;
            end else begin
                cur.cond = int'(br_cond); cur.pc = br_pc;
                cur.off = br_offset; cur.pred = br_pred_taken;
                m_valid = 1'b0;
                if (m_pend) begin
                    resolve(m_preq, m_flags);
                    m_pend = 1'b0;
                end else if (br_valid) begin
`ifdef FLAG_FWD_EN
                    resolve(cur, flag_we ? {z_in, v_in, n_in} : m_flags);
`else
                    if (flag_we) begin
                        m_pend = 1'b1;
                        m_preq = cur;
                    end else begin
                        resolve(cur, m_flags);
                    end
`endif
                end
                if (flag_we) m_flags = {z_in, v_in, n_in};
                m_ready = !m_pend;
            end
        end
    end

    // Compare process: every cycle, shortly after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (chk_on) begin
                chk("res_valid", 32'(res_valid), 32'(m_valid));
                chk("br_ready", 32'(br_ready), 32'(m_ready));
                chk("flags_q", 32'(flags_q), 32'(m_flags));
                chk("res_taken", 32'(res_taken), 32'(m_taken));
                chk("res_target", res_target, m_target);
                chk("res_flush", 32'(res_flush), 32'(m_valid & (m_taken ^ m_pred)));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_flags(input bit we, input bit z, input bit v, input bit n);
        flag_we = we; z_in = z; v_in = v; n_in = n;
    endtask

    task automatic drive_br(input bit vld, input int c, input logic [31:0] pc,
                            input logic [31:0] off, input bit pred);
        br_valid = vld; br_cond = 3'(c); br_pc = pc; br_offset = off; br_pred_taken = pred;
    endtask

    bit exp_pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        // Reset
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst flags_q", 32'(flags_q), 32'h0);
        chk("rst res_valid", 32'(res_valid), 32'h0);
        chk("rst br_ready", 32'(br_ready), 32'h1);
        chk("rst res_target", res_target, 32'h0);
        chk("rst res_flush", 32'(res_flush), 32'h0);
        chk_on = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        // Flag write z=1, then EQ branch
        set_flags(1, 1, 0, 0);
        @(negedge clk);
        set_flags(0, 0, 0, 0);
        drive_br(1, 1, 32'h100, 32'h20, 0);
        @(negedge clk);
        drive_br(0, 0, 0, 0, 0);
        chk("eq res_valid", 32'(res_valid), 32'h1);
        chk("eq res_taken", 32'(res_taken), 32'h1);
        chk("eq res_target", res_target, 32'h120);
        chk("eq res_flush", 32'(res_flush), 32'h1);
        @(negedge clk);
        chk("eq pulse ends", 32'(res_valid), 32'h0);

        // Hazard: flag write and LT branch together
        set_flags(1, 0, 0, 1);
        drive_br(1, 3, 32'h40, 32'h10, 1);
        @(negedge clk);
        set_flags(0, 0, 0, 0);
`ifdef FLAG_FWD_EN
        drive_br(0, 0, 0, 0, 0);
        chk("fwd br_ready", 32'(br_ready), 32'h1);
        chk("fwd res_valid", 32'(res_valid), 32'h1);
        chk("fwd res_taken", 32'(res_taken), 32'h1);
        chk("fwd res_target", res_target, 32'h50);
        chk("fwd res_flush", 32'(res_flush), 32'h0);
`else
        chk("hz br_ready low", 32'(br_ready), 32'h0);
        chk("hz res_valid early", 32'(res_valid), 32'h0);
        @(negedge clk);
        drive_br(0, 0, 0, 0, 0);
        chk("hz br_ready back", 32'(br_ready), 32'h1);
        chk("hz res_valid", 32'(res_valid), 32'h1);
        chk("hz res_taken", 32'(res_taken), 32'h1);
        chk("hz res_target", res_target, 32'h50);
        chk("hz res_flush", 32'(res_flush), 32'h0);
`endif
        @(negedge clk);

        // Wrap-around targets
        drive_br(1, 7, 32'hFFFF_FFF0, 32'h20, 1);
        @(negedge clk);
        drive_br(0, 0, 0, 0, 0);
        chk("wrap uncond target", res_target, 32'h0000_0010);
        chk("wrap uncond taken", 32'(res_taken), 32'h1);
        set_flags(1, 1, 0, 0);
        @(negedge clk);
        set_flags(0, 0, 0, 0);
        drive_br(1, 0, 32'hFFFF_FFFC, 32'h80, 0);
        @(negedge clk);
        drive_br(0, 0, 0, 0, 0);
        chk("wrap neq taken", 32'(res_taken), 32'h0);
        chk("wrap neq target", res_target, 32'h0000_0000);
        chk("wrap neq flush", 32'(res_flush), 32'h0);

        // Back-to-back sweep over all conditions, flags {z,v,n}=011
        set_flags(1, 0, 1, 1);
        @(negedge clk);
        set_flags(0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                chk($sformatf("sweep%0d valid", i - 1), 32'(res_valid), 32'h1);
                chk($sformatf("sweep%0d taken", i - 1), 32'(res_taken), 32'(exp_pat[i - 1]));
            end
            if (i < 8) drive_br(1, i, 32'h200 + 32'(4 * i), 32'h8, 32'($urandom_range(0, 1)) != 0);
            else drive_br(0, 0, 0, 0, 0);
            @(negedge clk);
        end

        // Reset in the middle of a hazard stall
        set_flags(1, 1, 0, 0);
        drive_br(1, 1, 32'h300, 32'h40, 0);
        @(negedge clk);
        set_flags(0, 0, 0, 0);
        drive_br(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        chk("rst hold flags_q", 32'(flags_q), 32'h0);
        chk("rst hold res_valid", 32'(res_valid), 32'h0);
        chk("rst hold br_ready", 32'(br_ready), 32'h1);
        chk("rst hold state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst hold no result", 32'(res_valid), 32'h0);
        chk("rst hold ready after", 32'(br_ready), 32'h1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            set_flags($urandom_range(0, 3) == 0, $urandom_range(0, 1) != 0,
                      $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
            if (m_ready) begin
                drive_br($urandom_range(0, 2) != 0, int'($urandom_range(0, 7)),
                         ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom,
                         $urandom, $urandom_range(0, 1) != 0);
            end
            @(negedge clk);
        end
        drive_br(0, 0, 0, 0, 0);
        set_flags(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
